// File: rtl/simple_edge_detect_generate.sv
// Source-domain stimulus generator for the edge-detect CDC test pair.
//
// Drives an 8-bit walking pattern on captureData and a toggle-encoded strobe on
// captureEdge. Every word is held for max(setupCycles,1) cycles before its strobe
// toggle and for max(holdCycles,1) cycles after it. So the capture block in the
// other clock domain can sample captureData on any captureEdge transition.
//
// Optional build macro: ERROR_INJECT_EN adds the injectError input and the
// numInjected output. A pulse on injectError corrupts bit 0 of the next word
// that is loaded.
//
// Timing, with start sampled in cycle t, S = max(setupCycles,1) and
// H = max(holdCycles,1):
//   captureData valid at t+1, captureEdge flips at t+1+S, next word at t+2+S+H.
module simple_edge_detect_generate #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] setupCycles,
  input  logic [CNT_W-1:0] holdCycles,
  input  logic [CNT_W-1:0] burstLength,
`ifdef ERROR_INJECT_EN
  input  logic             injectError,
  output logic [CNT_W-1:0] numInjected,
`endif
  output logic [7:0]       captureData,
  output logic             captureEdge,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] numEdgesSent
);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StToggle,
    StHold
  } state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic [7:0]       pattern_q, pattern_d;  // uncorrupted walking-pattern state
  logic [7:0]       data_q, data_d;        // word actually driven out
  logic             edge_q, edge_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [CNT_W-1:0] burst_q, burst_d;      // edges sent in the current burst
  logic [CNT_W-1:0] phase_q, phase_d;      // cycles left in SETUP or HOLD
  logic             stop_q, stop_d;

  logic [CNT_W-1:0] setup_eff;
  logic [CNT_W-1:0] hold_eff;
  logic             phase_last;
  logic             burst_end;
  logic             load_word;
  logic [7:0]       next_word;
  logic [7:0]       word_mask;

`ifdef ERROR_INJECT_EN
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] injected_q, injected_d;
`endif

  // Walking pattern; any value outside the cycle (including the reset value)
  // restarts it at 0x81.
  function automatic logic [7:0] pattern_next(input logic [7:0] cur);
    logic [7:0] nxt;
    unique case (cur)
      8'h81:   nxt = 8'h42;
      8'h42:   nxt = 8'h24;
      8'h24:   nxt = 8'h18;
      default: nxt = 8'h81;
    endcase
    return nxt;
  endfunction

  assign setup_eff  = (setupCycles == '0) ? CntOne : setupCycles;
  assign hold_eff   = (holdCycles == '0) ? CntOne : holdCycles;
  assign phase_last = (phase_q == CntOne);
  assign next_word  = pattern_next(pattern_q);

  // The burst ends at HOLD expiry if the count is reached or stop was seen.
  // A stop that arrives in the expiry cycle itself is honoured as well.
  assign burst_end = ((burstLength != '0) && (burst_q == burstLength)) || stop_q || stop;

  // Next-state and registered-output logic. The edge flips and the counters
  // increment on the transition into TOGGLE. The new edge value is therefore
  // visible during the TOGGLE cycle. Words are loaded only on entry to SETUP.
  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    done_d    = 1'b0;
    sent_d    = sent_q;
    burst_d   = burst_q;
    phase_d   = phase_q;
    stop_d    = stop_q;
    load_word = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StSetup;
          load_word = 1'b1;
          burst_d   = '0;
          stop_d    = stop;  // start and stop together still send one word
          phase_d   = setup_eff;
        end
      end

      StSetup: begin
        stop_d = stop_q | stop;
        if (phase_last) begin
          state_d = StToggle;
          edge_d  = ~edge_q;
          sent_d  = sent_q + CntOne;
          burst_d = burst_q + CntOne;
        end else begin
          phase_d = phase_q - CntOne;
        end
      end

      StToggle: begin
        stop_d  = stop_q | stop;
        state_d = StHold;
        phase_d = hold_eff;
      end

      StHold: begin
        stop_d = stop_q | stop;
        if (phase_last) begin
          if (burst_end) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d   = StSetup;
            load_word = 1'b1;
            phase_d   = setup_eff;
          end
        end else begin
          phase_d = phase_q - CntOne;
        end
      end

      default: state_d = StIdle;
    endcase
  end

`ifdef ERROR_INJECT_EN
  // One-shot corruption. Arm on a pulse and spend the arm on the next load.
  // A pulse while already armed is dropped.
  always_comb begin
    armed_d    = armed_q;
    injected_d = injected_q;
    word_mask  = 8'h00;
    if (load_word && armed_q) begin
      armed_d    = 1'b0;
      injected_d = injected_q + CntOne;
      word_mask  = 8'h01;
    end else if (injectError) begin
      armed_d = 1'b1;
    end
  end
`else
  assign word_mask = 8'h00;
`endif

  // Word loading. The pattern register always advances cleanly, so one
  // corrupted word does not disturb the rest of the sequence.
  always_comb begin
    pattern_d = pattern_q;
    data_d    = data_q;
    if (load_word) begin
      pattern_d = next_word;
      data_d    = next_word ^ word_mask;
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pattern_q <= 8'h00;
      data_q    <= 8'h00;
      edge_q    <= 1'b0;
      done_q    <= 1'b0;
      sent_q    <= '0;
      burst_q   <= '0;
      phase_q   <= '0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      data_q    <= data_d;
      edge_q    <= edge_d;
      done_q    <= done_d;
      sent_q    <= sent_d;
      burst_q   <= burst_d;
      phase_q   <= phase_d;
      stop_q    <= stop_d;
    end
  end

`ifdef ERROR_INJECT_EN
  // Injection arm flag and count of corrupted words.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q    <= 1'b0;
      injected_q <= '0;
    end else begin
      armed_q    <= armed_d;
      injected_q <= injected_d;
    end
  end

  assign numInjected = injected_q;
`endif

  assign captureData  = data_q;
  assign captureEdge  = edge_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign numEdgesSent = sent_q;

endmodule
